// File: rtl/alu_pkg.sv
// Shared ALU function codes and instruction-field encodings for the
// issue/decode logic around the combinational ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_MUL = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of alu_op/funct3/funct7 bits into the ALU function
// code, plus branch and unsupported-encoding flags.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  input  logic       funct7_b0,
  output logic [3:0] alu_ctrl,
  output logic       is_branch,
  output logic       illegal
);

  logic is_rtype;
  assign is_rtype = (alu_op == ALUOP_RTYPE);

  // Function-code, branch and illegal decode
  always_comb begin
    alu_ctrl  = ALU_ADD;
    is_branch = 1'b0;
    illegal   = 1'b0;
    case (alu_op)
      ALUOP_MEM: begin
        alu_ctrl = ALU_ADD;
      end
      ALUOP_BRANCH: begin
        alu_ctrl  = ALU_SUB;
        is_branch = 1'b1;
        illegal   = (funct3 != F3_BEQ) && (funct3 != F3_BNE);
      end
      ALUOP_RTYPE, ALUOP_ITYPE: begin
        case (funct3)
          F3_ADD: begin
            // MUL and SUB selects together have no meaning; keep ADD and flag it
            if (is_rtype && funct7_b5 && funct7_b0) begin
              alu_ctrl = ALU_ADD;
              illegal  = 1'b1;
            end else if (is_rtype && funct7_b0) begin
              alu_ctrl = ALU_MUL;
            end else if (is_rtype && funct7_b5) begin
              alu_ctrl = ALU_SUB;
            end else begin
              alu_ctrl = ALU_ADD;
            end
          end
          F3_SLL:  alu_ctrl = ALU_SLL;
          F3_SLT:  alu_ctrl = ALU_SLT;
          F3_SLTU: alu_ctrl = ALU_SLT;
          F3_XOR:  alu_ctrl = ALU_XOR;
          F3_SR: begin
            alu_ctrl = ALU_SRL;
            illegal  = funct7_b5;
          end
          F3_OR:   alu_ctrl = ALU_OR;
          F3_AND:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: begin
        alu_ctrl = ALU_ADD;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-stage issue pipeline around an external combinational ALU:
// E drives the ALU ports, W captures result/zero and the branch decision.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic             funct7_b5,
  input  logic             funct7_b0,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             zero_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_branch_taken,
  output logic             out_illegal
);

  logic [3:0] dec_ctrl;
  logic       dec_branch;
  logic       dec_illegal;

  alu_ctrl_decode u_decode (
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7_b5 (funct7_b5),
    .funct7_b0 (funct7_b0),
    .alu_ctrl  (dec_ctrl),
    .is_branch (dec_branch),
    .illegal   (dec_illegal)
  );

  logic             e_valid_q,   e_valid_d;
  logic [WIDTH-1:0] alu_in1_q,   alu_in1_d;
  logic [WIDTH-1:0] alu_in2_q,   alu_in2_d;
  logic [3:0]       alu_ctrl_q,  alu_ctrl_d;
  logic             e_branch_q,  e_branch_d;
  logic             e_f3b0_q,    e_f3b0_d;
  logic             e_illegal_q, e_illegal_d;

  logic             out_valid_q,   out_valid_d;
  logic [WIDTH-1:0] out_result_q,  out_result_d;
  logic             out_zero_q,    out_zero_d;
  logic             out_taken_q,   out_taken_d;
  logic             out_illegal_q, out_illegal_d;

  logic w_free;
  logic e_adv;
  logic accept;

  assign w_free   = !out_valid_q || out_ready;
  assign e_adv    = e_valid_q && w_free;
  assign in_ready = !e_valid_q || w_free;
  assign accept   = in_valid && in_ready;

  // Next-state for both stages; ALU drive registers hold when E is not loaded
  always_comb begin
    e_valid_d     = e_valid_q;
    alu_in1_d     = alu_in1_q;
    alu_in2_d     = alu_in2_q;
    alu_ctrl_d    = alu_ctrl_q;
    e_branch_d    = e_branch_q;
    e_f3b0_d      = e_f3b0_q;
    e_illegal_d   = e_illegal_q;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_zero_d    = out_zero_q;
    out_taken_d   = out_taken_q;
    out_illegal_d = out_illegal_q;

    if (accept) begin
      e_valid_d   = 1'b1;
      alu_in1_d   = rs1_data;
      alu_in2_d   = rs2_data;
      alu_ctrl_d  = dec_ctrl;
      e_branch_d  = dec_branch;
      e_f3b0_d    = funct3[0];
      e_illegal_d = dec_illegal;
    end else if (e_adv) begin
      e_valid_d = 1'b0;
    end else begin
      e_valid_d = e_valid_q;
    end

    if (e_adv) begin
      out_valid_d   = 1'b1;
      out_result_d  = alu_result;
      out_zero_d    = zero_flag;
      // funct3[0] separates BNE from BEQ; illegal branches never take
      out_taken_d   = e_branch_q && !e_illegal_q && (e_f3b0_q ? !zero_flag : zero_flag);
      out_illegal_d = e_illegal_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid_q     <= 1'b0;
      alu_in1_q     <= {WIDTH{1'b0}};
      alu_in2_q     <= {WIDTH{1'b0}};
      alu_ctrl_q    <= ALU_ADD;
      e_branch_q    <= 1'b0;
      e_f3b0_q      <= 1'b0;
      e_illegal_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= {WIDTH{1'b0}};
      out_zero_q    <= 1'b0;
      out_taken_q   <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      e_valid_q     <= e_valid_d;
      alu_in1_q     <= alu_in1_d;
      alu_in2_q     <= alu_in2_d;
      alu_ctrl_q    <= alu_ctrl_d;
      e_branch_q    <= e_branch_d;
      e_f3b0_q      <= e_f3b0_d;
      e_illegal_q   <= e_illegal_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_zero_q    <= out_zero_d;
      out_taken_q   <= out_taken_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign alu_in1          = alu_in1_q;
  assign alu_in2          = alu_in2_q;
  assign alu_ctrl         = alu_ctrl_q;
  assign out_valid        = out_valid_q;
  assign out_result       = out_result_q;
  assign out_zero         = out_zero_q;
  assign out_branch_taken = out_taken_q;
  assign out_illegal      = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, directed scenarios and random
// traffic checked against an in-order scoreboard of expected results.
module tb_alu_issue_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       alu_op = 2'b00;
  logic [2:0]       funct3 = 3'b000;
  logic             funct7_b5 = 1'b0;
  logic             funct7_b0 = 1'b0;
  logic [WIDTH-1:0] rs1_data = 8'h00;
  logic [WIDTH-1:0] rs2_data = 8'h00;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             zero_flag;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_branch_taken;
  logic             out_illegal;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(WIDTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .alu_op           (alu_op),
    .funct3           (funct3),
    .funct7_b5        (funct7_b5),
    .funct7_b0        (funct7_b0),
    .rs1_data         (rs1_data),
    .rs2_data         (rs2_data),
    .alu_in1          (alu_in1),
    .alu_in2          (alu_in2),
    .alu_ctrl         (alu_ctrl),
    .alu_result       (alu_result),
    .zero_flag        (zero_flag),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_zero         (out_zero),
    .out_branch_taken (out_branch_taken),
    .out_illegal      (out_illegal)
  );

  // Stand-in for the combinational ALU
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_in1 & alu_in2;
      4'b0001: alu_result = alu_in1 | alu_in2;
      4'b0010: alu_result = alu_in1 + alu_in2;
      4'b0011: alu_result = alu_in1 << alu_in2;
      4'b0100: alu_result = alu_in1 - alu_in2;
      4'b0101: alu_result = alu_in1 >> alu_in2;
      4'b0110: alu_result = alu_in1 * alu_in2;
      4'b0111: alu_result = alu_in1 ^ alu_in2;
      4'b1000: alu_result = {7'd0, (alu_in1 < alu_in2)};
      default: alu_result = 8'h00;
    endcase
    zero_flag = (alu_result == 8'h00);
  end

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] ctrl;
    logic [7:0] res;
    logic       zero;
    logic       taken;
    logic       illegal;
    logic       chk;     // 0: result/ctrl not defined for this encoding
  } item_t;

  int    n_checks = 0;
  int    n_errors = 0;
  item_t sb[$];
  item_t last_item;
  bit    last_acc = 1'b0;
  bit    stall_pend = 1'b0;
  logic [11:0] stall_snap;
  bit    rdy = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected outcome of one request, straight from the instruction semantics
  function automatic item_t ref_model(input logic [1:0] op, input logic [2:0] f3,
                                      input logic b5, input logic b0,
                                      input logic [7:0] a, input logic [7:0] b);
    item_t it;
    int    ia, ib, x;
    ia = int'(a);
    ib = int'(b);
    it = '0;
    it.a = a;
    it.b = b;
    it.chk = 1'b1;
    x = 0;
    if (op == 2'b00) begin
      it.ctrl = 4'b0010; x = ia + ib;
    end else if (op == 2'b01) begin
      it.ctrl = 4'b0100; x = ia - ib;
      if (f3 == 3'd0)      it.taken = (a == b);
      else if (f3 == 3'd1) it.taken = (a != b);
      else                 it.illegal = 1'b1;
    end else begin
      case (f3)
        3'd0: begin
          if (op == 2'b10 && b5 && b0) begin it.illegal = 1'b1; it.chk = 1'b0; end
          else if (op == 2'b10 && b0)  begin it.ctrl = 4'b0110; x = ia * ib; end
          else if (op == 2'b10 && b5)  begin it.ctrl = 4'b0100; x = ia - ib; end
          else                         begin it.ctrl = 4'b0010; x = ia + ib; end
        end
        3'd1:    begin it.ctrl = 4'b0011; x = (ib >= 8) ? 0 : (ia << ib); end
        3'd2,
        3'd3:    begin it.ctrl = 4'b1000; x = (ia < ib) ? 1 : 0; end
        3'd4:    begin it.ctrl = 4'b0111; x = ia ^ ib; end
        3'd5:    begin it.ctrl = 4'b0101; x = (ib >= 8) ? 0 : (ia >> ib); it.illegal = b5; end
        3'd6:    begin it.ctrl = 4'b0001; x = ia | ib; end
        default: begin it.ctrl = 4'b0000; x = ia & ib; end
      endcase
    end
    it.res  = x[7:0];
    it.zero = (x[7:0] == 8'h00);
    return it;
  endfunction

  // One clock: check state left by the last edge, drive, record handshakes
  task automatic cyc(input bit iv, input logic [1:0] op, input logic [2:0] f3,
                     input logic b5, input logic b0,
                     input logic [7:0] a, input logic [7:0] b, output bit acc);
    item_t f;
    bit    exp_ov;
    @(negedge clk);
    if (last_acc) begin
      check_eq("alu_in1", alu_in1, last_item.a);
      check_eq("alu_in2", alu_in2, last_item.b);
      if (last_item.chk) check_eq("alu_ctrl", alu_ctrl, last_item.ctrl);
    end
    if (stall_pend)
      check_eq("stall_stable", {out_valid, out_result, out_zero, out_branch_taken, out_illegal}, stall_snap);
    exp_ov = (sb.size() >= 2) || (sb.size() == 1 && !last_acc);
    check_eq("out_valid", out_valid, exp_ov);

    in_valid = iv; alu_op = op; funct3 = f3; funct7_b5 = b5; funct7_b0 = b0;
    rs1_data = a; rs2_data = b; out_ready = rdy;
    #1;
    check_eq("in_ready", in_ready, (sb.size() < 2) || rdy);
    acc = iv && in_ready;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("sb_spurious_out", out_valid, 1'b0);
      end else begin
        f = sb.pop_front();
        if (f.chk) begin
          check_eq("out_result", out_result, f.res);
          check_eq("out_zero", out_zero, f.zero);
        end
        check_eq("out_taken", out_branch_taken, f.taken);
        check_eq("out_illegal", out_illegal, f.illegal);
      end
    end
    stall_pend = out_valid && !out_ready;
    stall_snap = {out_valid, out_result, out_zero, out_branch_taken, out_illegal};
    last_acc = acc;
    if (acc) begin
      last_item = ref_model(op, f3, b5, b0, a, b);
      sb.push_back(last_item);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic b5,
                      input logic b0, input logic [7:0] a, input logic [7:0] b);
    bit acc;
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      cyc(1'b1, op, f3, b5, b0, a, b, acc);
      n++;
    end
    if (!acc) check_eq("send_timeout", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 8'h00, 8'h00, acc);
  endtask

  task automatic drain();
    int n;
    rdy = 1'b1;
    n = 0;
    while ((sb.size() > 0 || last_acc) && n < 50) begin
      idle(1);
      n++;
    end
    check_eq("drain_empty", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_alu_ctrl", alu_ctrl, 4'b0010);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_alu_in1", alu_in1, 8'h00);
    check_eq("rst_alu_in2", alu_in2, 8'h00);
    check_eq("rst_out_result", out_result, 8'h00);
    check_eq("rst_out_flags", {out_zero, out_branch_taken, out_illegal}, 3'b000);
    reset = 1'b0;
    sb.delete();
    last_acc = 1'b0;
    stall_pend = 1'b0;
  endtask

  initial begin
    bit         acc;
    logic [1:0] op;
    logic [2:0] f3;
    logic [7:0] a, b;

    do_reset();

    rdy = 1'b1;
    send(2'b10, 3'b000, 1'b0, 1'b0, 8'h30, 8'h10);
    send(2'b10, 3'b000, 1'b1, 1'b0, 8'h30, 8'h10);
    drain();

    send(2'b01, 3'b000, 1'b0, 1'b0, 8'h5A, 8'h5A);
    send(2'b01, 3'b001, 1'b0, 1'b0, 8'h5A, 8'h5A);
    send(2'b01, 3'b001, 1'b0, 1'b0, 8'h5A, 8'h11);
    drain();

    // Backpressure with three MULs
    rdy = 1'b0;
    send(2'b10, 3'b000, 1'b0, 1'b1, 8'h03, 8'h05);
    send(2'b10, 3'b000, 1'b0, 1'b1, 8'h10, 8'h10);
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'b10, 3'b000, 1'b0, 1'b1, 8'h0F, 8'h02, acc);
    check_eq("bp_hold_result", out_result, 8'h0F);
    rdy = 1'b1;
    send(2'b10, 3'b000, 1'b0, 1'b1, 8'h0F, 8'h02);
    drain();

    send(2'b10, 3'b101, 1'b1, 1'b0, 8'h80, 8'h01);
    send(2'b01, 3'b100, 1'b0, 1'b0, 8'h22, 8'h22);
    send(2'b10, 3'b000, 1'b1, 1'b1, 8'h22, 8'h01);
    send(2'b10, 3'b010, 1'b0, 1'b0, 8'h01, 8'hFF);
    send(2'b11, 3'b011, 1'b0, 1'b0, 8'h01, 8'hFF);
    send(2'b10, 3'b011, 1'b0, 1'b0, 8'hFF, 8'h01);
    send(2'b11, 3'b010, 1'b0, 1'b0, 8'hFF, 8'h01);
    drain();

    // Reset with both stages full, then a clean op
    rdy = 1'b0;
    send(2'b00, 3'b000, 1'b0, 1'b0, 8'h11, 8'h22);
    send(2'b00, 3'b000, 1'b0, 1'b0, 8'h33, 8'h44);
    do_reset();
    rdy = 1'b1;
    send(2'b00, 3'b111, 1'b0, 1'b0, 8'h01, 8'h02);
    drain();

    for (int i = 0; i < 600; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      op  = 2'($urandom_range(0, 3));
      f3  = 3'($urandom_range(0, 7));
      a   = 8'($urandom);
      b   = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      if ($urandom_range(0, 3) == 0) b = a;
      cyc(($urandom_range(0, 3) != 0), op, f3, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), a, b, acc);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Drives the ALU operand/control interface (in1, in2, alu_ctrl) and captures its result and zero flag (alu_result, zero_flag).
- Decodes alu_op/funct3/funct7 bits into the 4-bit ALU function code, then returns the registered result over a valid/ready handshake.
- Sits between the register-read stage and writeback/branch logic.
- Two-stage pipeline (E = ALU drive, W = result capture) with full backpressure.

Parameters:
- WIDTH, 8, datapath width; must equal the ALU operand width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- alu_op  input  2  00 load/store (ADD), 01 branch, 10 R-type, 11 I-type
- funct3  input  3  instruction funct3
- funct7_b5  input  1  funct7[5] (SUB/SRA select)
- funct7_b0  input  1  funct7[0] (MUL select, R-type only)
- rs1_data  input  WIDTH  operand 1
- rs2_data  input  WIDTH  operand 2 or immediate
- alu_in1  output  WIDTH  to ALU in1
- alu_in2  output  WIDTH  to ALU in2
- alu_ctrl  output  4  to ALU alu_ctrl
- alu_result  input  WIDTH  from ALU
- zero_flag  input  1  from ALU
- out_valid  output  1  result valid
- out_ready  input  1  consumer ready
- out_result  output  WIDTH  captured alu_result
- out_zero  output  1  captured zero_flag
- out_branch_taken  output  1  branch decision (0 for non-branch ops)
- out_illegal  output  1  unsupported encoding flag

Behaviour:
- Function codes: AND 0000, OR 0001, ADD 0010, SLL 0011, SUB 0100, SRL 0101, MUL 0110, XOR 0111, SLT 1000. Codes 1001–1111 are never driven.
- Decode for alu_op 10/11 by funct3:
  - 000: ADD. SUB if alu_op=10 and funct7_b5=1. MUL if alu_op=10 and funct7_b0=1. MUL and SUB both set -> illegal.
  - 001 SLL; 010 and 011 SLT (unsigned compare); 100 XOR; 110 OR; 111 AND.
  - 101: SRL if funct7_b5=0. SRA (funct7_b5=1) -> illegal, drive SRL.
- alu_op 00 -> ADD, funct3 ignored.
- alu_op 01 -> SUB:
  - funct3 000 (BEQ): taken = zero_flag.
  - funct3 001 (BNE): taken = !zero_flag.
  - Other funct3 -> illegal, taken = 0.
- Illegal ops still flow through the pipeline, with out_illegal=1 and out_branch_taken=0.
- Stage E register holds alu_in1, alu_in2, alu_ctrl, is_branch, funct3[0], illegal, e_valid. The ALU is combinational; its outputs are sampled into stage W.
- Stage W register holds out_result, out_zero, out_branch_taken, out_illegal, out_valid. Branch decision is computed from zero_flag at E->W transfer.
- Advance rules:
  - w_free = !out_valid || out_ready.
  - e_adv = e_valid && w_free.
  - in_ready = !e_valid || w_free.
- Latency: request accepted at edge N appears on ALU ports after edge N; out_valid rises after edge N+1. Throughput is 1/cycle with out_ready held high.
- When E is empty or stalled, alu_in1/alu_in2/alu_ctrl hold their last values (no toggling).
- Simultaneous W drain and E->W transfer in one cycle: W loads new data and out_valid stays 1.
- Stall: all out_* remain stable while out_valid && !out_ready.
- Reset (also mid-operation): e_valid=0, out_valid=0, alu_in1=0, alu_in2=0, alu_ctrl=0010, out_result=0, out_zero=0, out_branch_taken=0, out_illegal=0. in_ready=1 from the first cycle after reset. In-flight ops are discarded.
- Width: MUL result truncated to WIDTH by the ALU. No sign extension anywhere.

Decomposition:
- Shared package alu_pkg:
  - ALU_AND..ALU_SLT 4-bit constants.
  - ALUOP_MEM/BRANCH/RTYPE/ITYPE 2-bit constants.
  - F3_BEQ/F3_BNE constants.
- Sub-module alu_ctrl_decode: purely combinational (alu_op, funct3, funct7_b5, funct7_b0) -> (alu_ctrl, is_branch, illegal). Reusable by the future control unit.
- Pipeline/handshake logic remains in alu_issue_ctrl.

Test Plan:
- R-type ADD then SUB: rs1=0x30, rs2=0x10, funct7_b5 0 then 1, out_ready=1 -> alu_ctrl 0010 then 0100 on consecutive cycles; out_result 0x40 then 0x20, each two cycles after acceptance.
- BEQ: alu_op=01, funct3=000, rs1=rs2=0x5A -> alu_ctrl 0100, out_zero=1, out_branch_taken=1. Same with BNE -> out_branch_taken=0.
- Backpressure: 3 back-to-back MULs (0x03*0x05, 0x10*0x10, 0x0F*0x02) with out_ready=0 for 4 cycles:
  - in_ready drops after 2 accepts; out_result holds 0x0F stable.
  - On out_ready=1, outputs are 0x0F, 0x00, 0x1E in order, none lost or duplicated.
- Illegal: alu_op=10, funct3=101, funct7_b5=1, rs1=0x80, rs2=1 -> out_illegal=1, alu_ctrl 0101, out_result 0x40. Branch funct3=100 -> out_illegal=1, taken=0.
- SLT/SLTU: rs1=0x01, rs2=0xFF with funct3 010 and 011 -> alu_ctrl 1000, out_result 0x01 for both. Swapped operands -> out_result 0x00, out_zero=1.
- Reset mid-flight: assert reset with E and W full -> next cycle out_valid=0, alu_ctrl=0010, in_ready=1. The first post-reset op completes normally with no stale output.
